pkt_arbiter: RTL and testbench
==============================

# pkt_arbiter

Round-robin packet arbiter that shares one registered AXI-Stream output between NUM_REQ upstream row streams, e.g. the per-row adder-tree outputs feeding the output module. Once a requester is granted, it holds the output until its packet ends on tlast. A packet is also forced to end after MAX_BEATS beats, so one runaway row cannot starve the others. The block tags each output beat with the source id and keeps packet and error status for the host-side control logic.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (≥2)
- DATA_WIDTH, 18, beat width
- MAX_BEATS, 64, maximum beats per granted packet (≥2)
- IDW, $clog2(NUM_REQ), id width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- s_axis_tvalid  in  NUM_REQ  per-requester valid
- s_axis_tdata  in  DATA_WIDTH*NUM_REQ  requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tlast  in  NUM_REQ  per-requester end of packet
- s_axis_tready  out  NUM_REQ  per-requester ready
- m_axis_tvalid  out  1  registered output valid
- m_axis_tdata  out  DATA_WIDTH  registered output data
- m_axis_tlast  out  1  registered end of packet, including forced ends
- m_axis_tid  out  IDW  source requester of the beat
- m_axis_tready  in  1  downstream ready
- pkt_count  out  16  count of packets completed at the output, wraps 0xFFFF→0
- err_trunc  out  1  sticky; set on any forced packet end
- busy  out  1  high while in state LOCK

## Operation
- Reset values: state IDLE, last_grant=NUM_REQ-1, grant=0, beat_cnt=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, pkt_count=0, err_trunc=0, s_axis_tready=0.
- Output update rule: can_update = m_axis_tready || !m_axis_tvalid. The output register loads only when can_update is high.
- IDLE:
  - All s_axis_tready are 0.
  - If any s_axis_tvalid is high, the winner is the first valid index found by scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
  - On a winner: grant<=winner, beat_cnt<=0, state<=LOCK.
  - With no valid requester, stay in IDLE.
- LOCK:
  - s_axis_tready[grant] = can_update. All other readies are 0.
  - Accepted beat = s_axis_tvalid[grant] && s_axis_tready[grant].
  - On an accepted beat: m_axis_tdata<=data[grant], m_axis_tid<=grant, m_axis_tvalid<=1, beat_cnt<=beat_cnt+1.
  - end = tlast[grant] || (beat_cnt==MAX_BEATS-1). m_axis_tlast<=end.
  - If end: state<=IDLE, last_grant<=grant.
  - If end and tlast[grant]==0: err_trunc<=1. The requester's remaining beats form a new packet after re-arbitration.
  - When can_update is high and no beat is accepted: m_axis_tvalid<=0.
- Held grant: while in LOCK, drops of s_axis_tvalid[grant] create output bubbles. Other requesters are ignored until end.
- pkt_count increments on an output handshake (m_axis_tvalid && m_axis_tready) with m_axis_tlast=1. Forced ends count.
- Output stability: m_axis_tdata, m_axis_tlast and m_axis_tid stay unchanged while m_axis_tvalid=1 and m_axis_tready=0.
- Reset mid-packet: everything returns to reset values next edge. The beat in flight is dropped and no tlast is emitted.

## Timing
- Arbitration: 1 cycle. A valid request seen in IDLE at edge n gives LOCK and tready from cycle n+1.
- Data latency: 1 cycle. A beat accepted at edge k appears on m_axis at cycle k+1.
- Throughput: one beat per cycle within a packet when upstream valid and downstream ready stay high.
- Packet gap: exactly one IDLE cycle between packets. The packet ending at edge k is followed by arbitration at edge k+1 and the next beat accepted at edge k+2 at the earliest.
- Fairness: a requester continuously valid waits at most NUM_REQ-1 packets between its grants.
- Backpressure is combinational from m_axis_tready to s_axis_tready[grant]. There is no other combinational input→output path.

## Test plan
- Basic round-robin (NUM_REQ=3, ready=1): all three requesters valid with 2-beat packets, data 0x10/0x11, 0x20/0x21, 0x30/0x31 → output order tid 0,0,1,1,2,2 with matching data; tlast on the 2nd and 4th, 6th beats; one bubble between packets; pkt_count=3.
- Rotation:
  - After a grant to req 1, req 0 and req 2 both valid → req 2 is granted next, then req 0.
  - A lone persistent requester is re-granted every packet.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet → no beat lost or duplicated; output stays stable while stalled; s_axis_tready[grant] mirrors can_update.
- Forced end (MAX_BEATS=4): req 0 sends 6 beats with tlast only on beat 6 →
  - output beats 1–4 with tlast on beat 4, and err_trunc=1;
  - beats 5–6 follow as a new packet after one arbitration cycle;
  - pkt_count=2.
- Grant hold: req 1 drops valid for 3 cycles mid-packet while req 2 is valid → 3 output bubbles, req 2 stays unserved until req 1's tlast.
- Reset mid-packet: assert rst during beat 2 of a 4-beat packet → next cycle all outputs are at reset values; the following packet from req 0 is granted normally; pkt_count=0.

Source files
------------

// File: rtl/pkt_arbiter_if.sv
// pkt_arbiter_if
//   Stream bundle around the packet arbiter: NUM_REQ upstream AXI-Stream
//   request lanes (flattened) and one downstream AXI-Stream output tagged
//   with the source id.
//   modport slave  : arbiter view (consumes requests, drives the output)
//   modport master : environment view (drives requests, sinks the output)
//   s_axis_tvalid/tlast/tready : NUM_REQ bits, one per requester
//   s_axis_tdata               : requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tvalid/tdata/tlast/tid/tready : shared output stream
interface pkt_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 18,
   parameter int IDW        = $clog2(NUM_REQ)
) ();
   logic [NUM_REQ-1:0]            s_axis_tvalid;
   logic [DATA_WIDTH*NUM_REQ-1:0] s_axis_tdata;
   logic [NUM_REQ-1:0]            s_axis_tlast;
   logic [NUM_REQ-1:0]            s_axis_tready;

   logic                          m_axis_tvalid;
   logic [DATA_WIDTH-1:0]         m_axis_tdata;
   logic                          m_axis_tlast;
   logic [IDW-1:0]                m_axis_tid;
   logic                          m_axis_tready;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
   );
endinterface

// File: rtl/pkt_arbiter.sv
// pkt_arbiter
//   Round-robin packet arbiter sharing one registered AXI-Stream output
//   between NUM_REQ row streams. A granted requester owns the output until
//   tlast, or until MAX_BEATS beats have passed (forced end, sticky error).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; pick next valid requester after last_grant
//   LOCK  | grant owns the output; beats flow until tlast or MAX_BEATS
//
//   Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   bus        : pkt_arbiter_if.slave (request lanes + tagged output)
//   pkt_count  : packets completed at the output (wrapping 16-bit)
//   err_trunc  : sticky, set on any forced packet end
//   busy       : high while in LOCK
module pkt_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 18,
   parameter int MAX_BEATS  = 64,
   parameter int IDW        = $clog2(NUM_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   pkt_arbiter_if.slave        bus,
   output logic [15:0]         pkt_count,
   output logic                err_trunc,
   output logic                busy
);

   localparam int BCW = $clog2(MAX_BEATS);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t                state_q, state_d;
   logic [IDW-1:0]        grant_q, last_grant_q;
   logic [IDW-1:0]        winner;
   logic                  winner_vld;
   logic [BCW-1:0]        beat_cnt_q;
   logic                  can_update;
   logic                  accept;
   logic                  pkt_end;

   logic                  m_tvalid_q;
   logic [DATA_WIDTH-1:0] m_tdata_q;
   logic                  m_tlast_q;
   logic [IDW-1:0]        m_tid_q;

   logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_data[i] = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign can_update = bus.m_axis_tready || !m_tvalid_q;
   assign accept     = (state_q == LOCK) && bus.s_axis_tvalid[grant_q] && can_update;
   assign pkt_end    = bus.s_axis_tlast[grant_q] || (beat_cnt_q == BCW'(MAX_BEATS-1));

   // Scan last_grant+1, last_grant+2, ... so the previous owner is checked last.
   always_comb begin
      logic [IDW-1:0] idx;
      winner     = '0;
      winner_vld = 1'b0;
      idx        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
         if (!winner_vld && bus.s_axis_tvalid[idx]) begin
            winner     = idx;
            winner_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (winner_vld)        state_d = LOCK;
         LOCK: if (accept && pkt_end) state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Only the owner sees ready, and it follows downstream backpressure directly.
   always_comb begin
      bus.s_axis_tready = '0;
      busy              = (state_q == LOCK);
      if (state_q == LOCK) bus.s_axis_tready[grant_q] = can_update;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q      <= '0;
         last_grant_q <= IDW'(NUM_REQ-1);
         beat_cnt_q   <= '0;
         m_tvalid_q   <= 1'b0;
         m_tdata_q    <= '0;
         m_tlast_q    <= 1'b0;
         m_tid_q      <= '0;
         pkt_count    <= '0;
         err_trunc    <= 1'b0;
      end else begin
         if (state_q == IDLE && winner_vld) begin
            grant_q    <= winner;
            beat_cnt_q <= '0;
         end
         if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (pkt_end) begin
               last_grant_q <= grant_q;
               // Remaining beats of a truncated packet re-arbitrate as a new packet.
               if (!bus.s_axis_tlast[grant_q]) err_trunc <= 1'b1;
            end
         end
         if (can_update) begin
            if (accept) begin
               m_tvalid_q <= 1'b1;
               m_tdata_q  <= req_data[grant_q];
               m_tlast_q  <= pkt_end;
               m_tid_q    <= grant_q;
            end else begin
               m_tvalid_q <= 1'b0;
            end
         end
         if (m_tvalid_q && bus.m_axis_tready && m_tlast_q) pkt_count <= pkt_count + 16'd1;
      end
   end

   assign bus.m_axis_tvalid = m_tvalid_q;
   assign bus.m_axis_tdata  = m_tdata_q;
   assign bus.m_axis_tlast  = m_tlast_q;
   assign bus.m_axis_tid    = m_tid_q;

endmodule

// File: tb/tb_pkt_arbiter.sv
// tb_pkt_arbiter
//   Scoreboard bench for pkt_arbiter (NUM_REQ=3, DATA_WIDTH=18, MAX_BEATS=4).
//   Expected output beats are queued as request beats are loaded and popped
//   on each output handshake.
module tb_pkt_arbiter;

   localparam int NR = 3;
   localparam int DW = 18;
   localparam int MB = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pkt_count;
   logic        err_trunc;
   logic        busy;

   pkt_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   pkt_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .pkt_count (pkt_count),
      .err_trunc (err_trunc),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          exp_pkts = 0;
   beat_t       src_q [NR][$];
   logic [31:0] exp_q [$];
   int          stamp_q [$];
   int          exp_gap [$];
   logic        rdy_q [$];
   int          hold_sz [NR];
   int          hold_cnt [NR];
   logic        chk_rdy = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_word = '0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic beat(int id, logic [DW-1:0] data, logic last, logic out_last);
      logic [1:0] tid;
      tid = id[1:0];
      src_q[id].push_back('{data: data, last: last});
      exp_q.push_back({11'd0, out_last, tid, data});
      if (out_last) exp_pkts++;
   endtask

   function automatic logic src_busy();
      return (src_q[0].size() + src_q[1].size() + src_q[2].size()) > 0;
   endfunction

   task automatic step();
      logic [NR-1:0]    v, l, acc;
      logic [DW*NR-1:0] d;
      logic [31:0]      word;
      logic [NR-1:0]    rdy_exp;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() > 0) begin
            if (hold_cnt[i] > 0 && src_q[i].size() == hold_sz[i]) begin
               hold_cnt[i]--;
            end else begin
               v[i] = 1'b1;
               l[i] = src_q[i][0].last;
               d[i*DW +: DW] = src_q[i][0].data;
            end
         end
      end
      bus.s_axis_tvalid = v;
      bus.s_axis_tlast  = l;
      bus.s_axis_tdata  = d;
      bus.m_axis_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      #1;
      word = {11'd0, bus.m_axis_tlast, bus.m_axis_tid, bus.m_axis_tdata};
      if (stall_prev) check("stable", {bus.m_axis_tvalid, word[30:0]}, {1'b1, prev_word[30:0]});
      stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_word  = word;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
         if (exp_q.size() == 0) check("unexpected_beat", word, 32'hFFFF_FFFF);
         else check("beat", word, exp_q.pop_front());
         stamp_q.push_back(cyc);
      end
      if (chk_rdy) begin
         rdy_exp = '0;
         if (busy) rdy_exp[0] = bus.m_axis_tready || !bus.m_axis_tvalid;
         check("rdy_mirror", {29'd0, bus.s_axis_tready}, {29'd0, rdy_exp});
      end
      acc = v & bus.s_axis_tready;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NR; i++) if (acc[i]) void'(src_q[i].pop_front());
      @(negedge clk);
   endtask

   task automatic drain(string tag, int budget);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || src_busy()) && n < budget) begin
         step();
         n++;
      end
      check({tag, "_drained"}, {31'd0, (exp_q.size() > 0 || src_busy())}, 32'd0);
      step();
      step();
      check({tag, "_pkt_count"}, {16'd0, pkt_count}, exp_pkts);
   endtask

   task automatic check_gaps(string tag);
      check({tag, "_nbeats"}, stamp_q.size(), exp_gap.size() + 1);
      for (int i = 0; i < exp_gap.size() && i + 1 < stamp_q.size(); i++)
         check({tag, "_gap"}, stamp_q[i+1] - stamp_q[i], exp_gap[i]);
   endtask

   task automatic check_reset(string tag);
      check({tag, "_mout"}, {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid, bus.m_axis_tdata}, 32'd0);
      check({tag, "_cnt"}, {16'd0, pkt_count}, 32'd0);
      check({tag, "_err"}, {31'd0, err_trunc}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_sready"}, {29'd0, bus.s_axis_tready}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NR; i++) begin hold_sz[i] = 0; hold_cnt[i] = 0; end
      bus.s_axis_tvalid = '0;
      bus.s_axis_tlast  = '0;
      bus.s_axis_tdata  = '0;
      bus.m_axis_tready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_reset("reset");

      // basic round-robin
      stamp_q.delete();
      beat(0, 18'h10, 1'b0, 1'b0); beat(0, 18'h11, 1'b1, 1'b1);
      beat(1, 18'h20, 1'b0, 1'b0); beat(1, 18'h21, 1'b1, 1'b1);
      beat(2, 18'h30, 1'b0, 1'b0); beat(2, 18'h31, 1'b1, 1'b1);
      drain("basic", 40);
      exp_gap = '{1, 2, 1, 2, 1};
      check_gaps("basic");

      // rotation: grant req1, then req0 and req2 together -> req2 first
      beat(1, 18'h40, 1'b1, 1'b1);
      drain("rot_a1", 20);
      beat(2, 18'h60, 1'b1, 1'b1);
      beat(0, 18'h50, 1'b1, 1'b1);
      drain("rot_a2", 20);

      // lone persistent requester re-granted every packet
      stamp_q.delete();
      beat(1, 18'h41, 1'b1, 1'b1);
      beat(1, 18'h42, 1'b1, 1'b1);
      beat(1, 18'h43, 1'b1, 1'b1);
      drain("rot_b", 30);
      exp_gap = '{2, 2};
      check_gaps("rot_b");

      // backpressure during a 4-beat packet
      for (int r = 0; r < 5; r++) begin
         rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
         rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
      end
      chk_rdy = 1'b1;
      beat(0, 18'h3A0, 1'b0, 1'b0); beat(0, 18'h3A1, 1'b0, 1'b0);
      beat(0, 18'h3A2, 1'b0, 1'b0); beat(0, 18'h3A3, 1'b1, 1'b1);
      drain("bp", 60);
      chk_rdy = 1'b0;
      rdy_q.delete();
      check("bp_no_err", {31'd0, err_trunc}, 32'd0);

      // grant hold: req1 drops valid for 3 cycles while req2 waits
      stamp_q.delete();
      hold_sz[1] = 2; hold_cnt[1] = 3;
      beat(1, 18'h70, 1'b0, 1'b0); beat(1, 18'h71, 1'b0, 1'b0);
      beat(1, 18'h72, 1'b0, 1'b0); beat(1, 18'h73, 1'b1, 1'b1);
      beat(2, 18'h80, 1'b1, 1'b1);
      drain("hold", 40);
      exp_gap = '{1, 4, 1, 2};
      check_gaps("hold");
      check("hold_no_err", {31'd0, err_trunc}, 32'd0);

      // forced end after MAX_BEATS
      stamp_q.delete();
      beat(0, 18'h90, 1'b0, 1'b0); beat(0, 18'h91, 1'b0, 1'b0);
      beat(0, 18'h92, 1'b0, 1'b0); beat(0, 18'h93, 1'b0, 1'b1);
      beat(0, 18'h94, 1'b0, 1'b0); beat(0, 18'h95, 1'b1, 1'b1);
      drain("force", 40);
      exp_gap = '{1, 1, 1, 2, 1};
      check_gaps("force");
      check("force_err", {31'd0, err_trunc}, 32'd1);

      // reset during beat 2 of a 4-beat packet
      beat(0, 18'hB0, 1'b0, 1'b0);
      src_q[0].push_back('{data: 18'hB1, last: 1'b0});
      src_q[0].push_back('{data: 18'hB2, last: 1'b0});
      src_q[0].push_back('{data: 18'hB3, last: 1'b1});
      for (int n = 0; n < 10 && src_q[0].size() > 3; n++) step();
      check("mid_first_beat", src_q[0].size(), 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset("mid_reset");
      check("mid_exp_empty", exp_q.size(), 0);
      src_q[0].delete();
      exp_q.delete();
      exp_pkts = 0;
      beat(0, 18'hC0, 1'b1, 1'b1);
      drain("post_reset", 20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
